// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: word width, reset vector,
// instruction field positions and the fetch-stage state encoding.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions
  localparam int JIDX_MSB  = 25;
  localparam int JIDX_LSB  = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Branch displacement: sign-extended 16-bit immediate scaled to bytes
  function automatic logic [WORD_W-1:0] branch_disp(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port: request/address out, ready/data back.
interface fetch_unit_if;
  import mips_pkg::*;

  logic              req;
  logic [WORD_W-1:0] addr;
  logic              ready;
  logic [WORD_W-1:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/fetch_npc.sv
// Next-PC selection for a presented instruction: jump, taken branch
// or fall-through. Purely combinational so the pipelined core can reuse it.
module fetch_npc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc_plus4,
  input  logic [WORD_W-1:0] instr,
  input  logic              pcsrc,
  input  logic              jump,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] jump_target;
  logic [WORD_W-1:0] branch_target;
  logic              unused_op_bits;

  assign jump_target    = {pc_plus4[31:28], instr[JIDX_MSB:JIDX_LSB], 2'b00};
  assign branch_target  = pc_plus4 + branch_disp(instr[IMM_MSB:IMM_LSB]);
  // The opcode field does not influence the target address
  assign unused_op_bits = ^instr[OP_MSB:OP_LSB];

  // Jump wins over a taken branch
  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = jump_target;
    else if (pcsrc)
      next_pc = branch_target;
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register and instruction fetch stage. Issues word reads over a
// req/ready handshake, holds the fetched instruction for decode, and
// supports a flush/redirect that lets an in-flight read drain first.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              pcsrc,
  input  logic              jump,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  fetch_unit_if.master      imem,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [5:0]        op,
  output logic [5:0]        funct
);

  fetch_state_t      state_reg, state_next;
  logic [WORD_W-1:0] fetch_addr_reg, fetch_addr_next;
  logic [WORD_W-1:0] pc_reg, pc_next;
  logic [WORD_W-1:0] instr_reg, instr_next;
  logic              instr_valid_reg, instr_valid_next;
  logic [WORD_W-1:0] redirect_addr_reg, redirect_addr_next;
  logic [WORD_W-1:0] next_pc;
  logic              xfer;

  assign imem.req    = ((state_reg == FETCH) || (state_reg == DRAIN)) && !rst;
  assign imem.addr   = fetch_addr_reg;
  assign xfer        = imem.req && imem.ready;

  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign pc          = pc_reg;
  assign pc_plus4    = pc_reg + 32'd4;
  assign op          = instr_reg[OP_MSB:OP_LSB];
  assign funct       = instr_reg[FUNCT_MSB:FUNCT_LSB];

  fetch_npc u_npc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_reg),
    .pcsrc    (pcsrc),
    .jump     (jump),
    .next_pc  (next_pc)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= FETCH;
      fetch_addr_reg    <= RESET_PC;
      pc_reg            <= RESET_PC;
      instr_reg         <= '0;
      instr_valid_reg   <= 1'b0;
      redirect_addr_reg <= RESET_PC;
    end else begin
      state_reg         <= state_next;
      fetch_addr_reg    <= fetch_addr_next;
      pc_reg            <= pc_next;
      instr_reg         <= instr_next;
      instr_valid_reg   <= instr_valid_next;
      redirect_addr_reg <= redirect_addr_next;
    end
  end

  // Next-state logic: fetch, hold for decode, or drain a read that a flush orphaned
  always_comb begin
    state_next         = state_reg;
    fetch_addr_next    = fetch_addr_reg;
    pc_next            = pc_reg;
    instr_next         = instr_reg;
    instr_valid_next   = instr_valid_reg;
    redirect_addr_next = redirect_addr_reg;
    case (state_reg)
      FETCH: begin
        if (xfer) begin
          if (flush) begin
            fetch_addr_next = flush_pc;
          end else begin
            instr_next       = imem.rdata;
            pc_next          = fetch_addr_reg;
            instr_valid_next = 1'b1;
            state_next       = HOLD;
          end
        end else if (flush) begin
          // Address must stay stable until the pending read completes
          redirect_addr_next = flush_pc;
          state_next         = DRAIN;
        end
      end
      HOLD: begin
        if (flush) begin
          instr_valid_next = 1'b0;
          fetch_addr_next  = flush_pc;
          state_next       = FETCH;
        end else if (!stall) begin
          instr_valid_next = 1'b0;
          fetch_addr_next  = next_pc;
          state_next       = FETCH;
        end
      end
      DRAIN: begin
        if (xfer) begin
          fetch_addr_next = flush ? flush_pc : redirect_addr_reg;
          state_next      = FETCH;
        end else if (flush) begin
          redirect_addr_next = flush_pc;
        end
      end
      default: state_next = FETCH;
    endcase
  end

endmodule
